key_filter_3ch: RTL and testbench

Debounce and synchronise stage that sits directly upstream of the decoder block. It takes the three raw, bouncing push-button pins and produces clean, glitch-free key levels that drive the decoder's key_1/key_2/key_3 inputs. It also produces a one-cycle press-strobe per channel for later edge-driven logic. It contains three identical, independent filter channels.

---
 rtl/key_filter_3ch_pkg.sv | 17 +
 rtl/key_filter.sv | 104 ++++++++++
 rtl/key_filter_3ch.sv | 45 ++++
 tb/tb_key_filter_3ch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_filter_3ch_pkg.sv
// Shared constants for the three-channel key debounce filter:
// FSM encodings and the stability-window terminal counts.
package key_filter_3ch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    P_FILT = 2'd1,
    DOWN   = 2'd2,
    R_FILT = 2'd3
  } kf_state_e;

  // 20 ms at 50 MHz
  localparam int CNT_MAX_DEFAULT = 999_999;
  // Short window for simulation
  localparam int CNT_MAX_SIM = 9;

endpackage

// File: rtl/key_filter.sv
// One debounce channel: 2-flop synchroniser, stability counter and a
// press/release filter FSM producing a clean level and a press strobe.
module key_filter
  import key_filter_3ch_pkg::*;
#(
  parameter int   CNT_MAX    = CNT_MAX_DEFAULT,
  parameter logic KEY_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_out,
  output logic key_flag
);

  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

  logic      s1_q, s1_d;
  logic      ks_q, ks_d;
  kf_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic      key_q, key_d;
  logic      flag_q, flag_d;
  logic      ks_active;

  assign ks_active = (ks_q == KEY_ACTIVE);

  always_comb begin
    s1_d    = key_in;
    ks_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    flag_d  = 1'b0;

    // The counter is cleared on every state exit, so it never wraps.
    unique case (state_q)
      IDLE: begin
        if (ks_active) begin
          state_d = P_FILT;
          cnt_d   = '0;
        end
      end
      P_FILT: begin
        if (!ks_active) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TOP) begin
          state_d = DOWN;
          cnt_d   = '0;
          key_d   = KEY_ACTIVE;
          flag_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DOWN: begin
        if (!ks_active) begin
          state_d = R_FILT;
          cnt_d   = '0;
        end
      end
      R_FILT: begin
        if (ks_active) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TOP) begin
          state_d = IDLE;
          cnt_d   = '0;
          key_d   = ~KEY_ACTIVE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= ~KEY_ACTIVE;
      ks_q    <= ~KEY_ACTIVE;
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= ~KEY_ACTIVE;
      flag_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      ks_q    <= ks_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      flag_q  <= flag_d;
    end
  end

  assign key_out  = key_q;
  assign key_flag = flag_q;

endmodule

// File: rtl/key_filter_3ch.sv
// Three independent debounce channels feeding the decoder key inputs.
module key_filter_3ch
  import key_filter_3ch_pkg::*;
#(
  parameter int   CNT_MAX    = CNT_MAX_DEFAULT,
  parameter logic KEY_ACTIVE = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in_1,
  input  logic key_in_2,
  input  logic key_in_3,
  output logic key_1,
  output logic key_2,
  output logic key_3,
  output logic key_flag_1,
  output logic key_flag_2,
  output logic key_flag_3
);

  key_filter #(.CNT_MAX(CNT_MAX), .KEY_ACTIVE(KEY_ACTIVE)) u_ch1 (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .key_in   (key_in_1),
    .key_out  (key_1),
    .key_flag (key_flag_1)
  );

  key_filter #(.CNT_MAX(CNT_MAX), .KEY_ACTIVE(KEY_ACTIVE)) u_ch2 (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .key_in   (key_in_2),
    .key_out  (key_2),
    .key_flag (key_flag_2)
  );

  key_filter #(.CNT_MAX(CNT_MAX), .KEY_ACTIVE(KEY_ACTIVE)) u_ch3 (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .key_in   (key_in_3),
    .key_out  (key_3),
    .key_flag (key_flag_3)
  );

endmodule

// File: tb/tb_key_filter_3ch.sv
// Directed bench for key_filter_3ch with CNT_MAX=9, active-low keys, 20 ns clock.
module tb_key_filter_3ch;
  import key_filter_3ch_pkg::*;

  logic sys_clk;
  logic sys_rst_n;
  logic key_in_1, key_in_2, key_in_3;
  logic key_1, key_2, key_3;
  logic key_flag_1, key_flag_2, key_flag_3;
  logic [2:0] keys, flags;

  int n_vec;
  int n_err;

  assign keys  = {key_3, key_2, key_1};
  assign flags = {key_flag_3, key_flag_2, key_flag_1};

  key_filter_3ch #(.CNT_MAX(CNT_MAX_SIM), .KEY_ACTIVE(1'b0)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in_1   (key_in_1),
    .key_in_2   (key_in_2),
    .key_in_3   (key_in_3),
    .key_1      (key_1),
    .key_2      (key_2),
    .key_3      (key_3),
    .key_flag_1 (key_flag_1),
    .key_flag_2 (key_flag_2),
    .key_flag_3 (key_flag_3)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Drive key_in_2 low for len cycles, then high; record flag pulses and low output cycles.
  task automatic pulse_key2(input int len, output int flag_cnt, output int low_cnt);
    flag_cnt = 0;
    low_cnt  = 0;
    key_in_2 = 1'b0;
    for (int i = 0; i < len + 40; i++) begin
      if (i == len) key_in_2 = 1'b1;
      tick();
      if (key_flag_2) flag_cnt++;
      if (!key_2) low_cnt++;
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    key_in_1  = 1'b1;
    key_in_2  = 1'b1;
    key_in_3  = 1'b1;
    #35;
    n_vec++;
    if ({keys, flags} !== 6'b111_000) begin
      n_err++;
      $display("FAIL reset_values: got keys=%b flags=%b, want 111/000", keys, flags);
    end
    tick();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      n_vec++;
      if ({keys, flags} !== 6'b111_000) begin
        n_err++;
        $display("FAIL idle cyc%0d: got keys=%b flags=%b, want 111/000", i, keys, flags);
      end
    end
  endtask

  task automatic test_clean_press();
    key_in_1 = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      n_vec++;
      if ({keys, flags} !== 6'b111_000) begin
        n_err++;
        $display("FAIL press_wait t%0d: got keys=%b flags=%b, want 111/000", t, keys, flags);
      end
    end
    tick();
    n_vec++;
    if ({keys, flags} !== 6'b110_001) begin
      n_err++;
      $display("FAIL press_edge12: got keys=%b flags=%b, want 110/001", keys, flags);
    end
    tick();
    n_vec++;
    if ({keys, flags} !== 6'b110_000) begin
      n_err++;
      $display("FAIL press_flag_drop: got keys=%b flags=%b, want 110/000", keys, flags);
    end
    repeat (5) tick();
  endtask

  task automatic test_release();
    int low_cnt;
    int flag_cnt;
    // 5-cycle high glitch while pressed must not release.
    low_cnt  = 0;
    flag_cnt = 0;
    key_in_1 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 5) key_in_1 = 1'b0;
      tick();
      if (!key_1) low_cnt++;
      if (flags != 3'b000) flag_cnt++;
    end
    n_vec++;
    if (low_cnt !== 30 || flag_cnt !== 0) begin
      n_err++;
      $display("FAIL release_glitch: got low_cycles=%0d flag_cycles=%0d, want 30/0", low_cnt, flag_cnt);
    end
    // Genuine release: rises at edge 12, never flags.
    flag_cnt = 0;
    key_in_1 = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (flags != 3'b000) flag_cnt++;
      if (t == 12) begin
        n_vec++;
        if (key_1 !== 1'b0) begin
          n_err++;
          $display("FAIL release_t12: got key_1=%b, want 0", key_1);
        end
      end
      if (t == 13) begin
        n_vec++;
        if (keys !== 3'b111) begin
          n_err++;
          $display("FAIL release_t13: got keys=%b, want 111", keys);
        end
      end
    end
    n_vec++;
    if (flag_cnt !== 0) begin
      n_err++;
      $display("FAIL release_no_flag: got flag_cycles=%0d, want 0", flag_cnt);
    end
  endtask

  task automatic test_bounce();
    int bad;
    int flag_cnt;
    int low_cnt;
    bad = 0;
    for (int seg = 0; seg < 20; seg++) begin
      key_in_2 = (seg % 2 == 0) ? 1'b0 : 1'b1;
      repeat (3) begin
        tick();
        if (key_2 !== 1'b1 || flags !== 3'b000) bad++;
      end
    end
    key_in_2 = 1'b1;
    repeat (20) begin
      tick();
      if (key_2 !== 1'b1 || flags !== 3'b000) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL bounce_toggle: got bad_cycles=%0d, want 0", bad);
    end
    // The FSM sees ks at edges 2..len+1 and needs it low through edge 12,
    // so 11 pad cycles is the shortest accepted pulse.
    pulse_key2(9, flag_cnt, low_cnt);
    n_vec++;
    if (flag_cnt !== 0 || low_cnt !== 0) begin
      n_err++;
      $display("FAIL pulse9: got flags=%0d low=%0d, want 0/0", flag_cnt, low_cnt);
    end
    pulse_key2(10, flag_cnt, low_cnt);
    n_vec++;
    if (flag_cnt !== 0 || low_cnt !== 0) begin
      n_err++;
      $display("FAIL pulse10: got flags=%0d low=%0d, want 0/0", flag_cnt, low_cnt);
    end
    // Press at edge 12, release window restarts at edge 11 -> rise at edge 23.
    pulse_key2(11, flag_cnt, low_cnt);
    n_vec++;
    if (flag_cnt !== 1 || low_cnt !== 11) begin
      n_err++;
      $display("FAIL pulse11: got flags=%0d low=%0d, want 1/11", flag_cnt, low_cnt);
    end
  endtask

  task automatic test_simultaneous();
    key_in_1 = 1'b0;
    key_in_2 = 1'b0;
    key_in_3 = 1'b0;
    repeat (12) tick();
    n_vec++;
    if ({keys, flags} !== 6'b111_000) begin
      n_err++;
      $display("FAIL simul_t12: got keys=%b flags=%b, want 111/000", keys, flags);
    end
    tick();
    n_vec++;
    if ({keys, flags} !== 6'b000_111) begin
      n_err++;
      $display("FAIL simul_t13: got keys=%b flags=%b, want 000/111", keys, flags);
    end
    tick();
    n_vec++;
    if ({keys, flags} !== 6'b000_000) begin
      n_err++;
      $display("FAIL simul_t14: got keys=%b flags=%b, want 000/000", keys, flags);
    end
    key_in_1 = 1'b1;
    key_in_2 = 1'b1;
    key_in_3 = 1'b1;
    repeat (30) tick();
    n_vec++;
    if ({keys, flags} !== 6'b111_000) begin
      n_err++;
      $display("FAIL simul_release: got keys=%b flags=%b, want 111/000", keys, flags);
    end
  endtask

  task automatic test_reset_mid();
    key_in_3 = 1'b0;
    repeat (30) tick();
    n_vec++;
    if (keys !== 3'b011) begin
      n_err++;
      $display("FAIL mid_pre_key3: got keys=%b, want 011", keys);
    end
    // After 8 ticks channel 1 sits in P_FILT with cnt=5.
    key_in_1 = 1'b0;
    repeat (8) tick();
    #3;
    sys_rst_n = 1'b0;
    #2;
    n_vec++;
    if ({keys, flags} !== 6'b111_000) begin
      n_err++;
      $display("FAIL mid_async: got keys=%b flags=%b, want 111/000", keys, flags);
    end
    repeat (3) tick();
    n_vec++;
    if ({keys, flags} !== 6'b111_000) begin
      n_err++;
      $display("FAIL mid_held: got keys=%b flags=%b, want 111/000", keys, flags);
    end
    sys_rst_n = 1'b1;
    repeat (12) tick();
    n_vec++;
    if ({keys, flags} !== 6'b111_000) begin
      n_err++;
      $display("FAIL mid_t12: got keys=%b flags=%b, want 111/000", keys, flags);
    end
    tick();
    n_vec++;
    if ({keys, flags} !== 6'b010_101) begin
      n_err++;
      $display("FAIL mid_t13: got keys=%b flags=%b, want 010/101", keys, flags);
    end
    tick();
    n_vec++;
    if ({keys, flags} !== 6'b010_000) begin
      n_err++;
      $display("FAIL mid_t14: got keys=%b flags=%b, want 010/000", keys, flags);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
